// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared state encoding and width helper for the memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE   = 2'b00;
    localparam state_t c_ACCESS = 2'b01;
    localparam state_t c_DONE   = 2'b10;

    // Index width for n items, never narrower than one bit.
    function automatic int calc_gnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pick
//  Brief    : Combinational winner select; first set request at or above the
//             start pointer, wrapping upward.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_pick #(
    parameter int CLIENT_CNT = 2,
    parameter int GNT_WIDTH  = 1
) (
    input  logic [CLIENT_CNT-1:0] i_req,
    input  logic [GNT_WIDTH-1:0]  i_start,
    output logic [GNT_WIDTH-1:0]  o_gnt,
    output logic                  o_valid
);

    logic [CLIENT_CNT-1:0] w_rot;
    int                    w_sum;

    // Bit k of the rotated vector is the request of client (start + k) mod N.
    assign w_rot   = CLIENT_CNT'({i_req, i_req} >> i_start);
    assign o_valid = |i_req;

    always_comb begin
        o_gnt = '0;
        w_sum = 0;
        for (int k = CLIENT_CNT - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = int'(i_start) + k;
                if (w_sum >= CLIENT_CNT) begin
                    w_sum = w_sum - CLIENT_CNT;
                end
                o_gnt = GNT_WIDTH'(w_sum);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Multi-client arbiter onto a single memory port with configurable
//             read latency. Define MEM_ARB_ROUND_ROBIN_EN for round-robin
//             grant; fixed lowest-index priority otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int M_WIDTH     = 8,
    parameter int A_WIDTH     = 8,
    parameter int CLIENT_CNT  = 2,
    parameter int MEM_LATENCY = 1,
    parameter int GNT_WIDTH   = calc_gnt_width(CLIENT_CNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CLIENT_CNT-1:0]         requests,
    input  logic [A_WIDTH*CLIENT_CNT-1:0] addrs,
    input  logic [CLIENT_CNT-1:0]         wes,
    input  logic [M_WIDTH*CLIENT_CNT-1:0] data_outs,
    output logic [CLIENT_CNT-1:0]         readies,
    output logic [M_WIDTH-1:0]            rdata,
    output logic [A_WIDTH-1:0]            mem_addr,
    output logic                          mem_we,
    output logic [M_WIDTH-1:0]            mem_wdata,
    input  logic [M_WIDTH-1:0]            mem_rdata,
    output logic                          busy,
    output logic [GNT_WIDTH-1:0]          gnt_id
);

    localparam int                   CNT_WIDTH  = calc_gnt_width(MEM_LATENCY);
    localparam logic [CNT_WIDTH-1:0] c_LAT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_lat_cnt;
    logic                 r_is_wr;
    logic [GNT_WIDTH-1:0] w_pick_gnt;
    logic [GNT_WIDTH-1:0] w_start;
    logic                 w_pick_valid;
    logic                 w_grant;
    logic                 w_last_access;
    logic [A_WIDTH-1:0]   w_sel_addr;
    logic [M_WIDTH-1:0]   w_sel_wdata;
    logic                 w_sel_we;

    arb_pick #(
        .CLIENT_CNT (CLIENT_CNT),
        .GNT_WIDTH  (GNT_WIDTH)
    ) u_arb_pick (
        .i_req   (requests),
        .i_start (w_start),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_valid)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [GNT_WIDTH-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (int'(w_pick_gnt) == CLIENT_CNT - 1) ? '0 : w_pick_gnt + GNT_WIDTH'(1);
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    assign w_grant       = (r_state == c_IDLE) && w_pick_valid;
    // Writes occupy one ACCESS cycle; reads run until the counter drains.
    assign w_last_access = (r_state == c_ACCESS) && (r_is_wr || (r_lat_cnt == '0));
    assign busy          = (r_state != c_IDLE);

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < CLIENT_CNT; i++) begin
            if (w_pick_gnt == GNT_WIDTH'(i)) begin
                w_sel_addr  = addrs[A_WIDTH*i +: A_WIDTH];
                w_sel_wdata = data_outs[M_WIDTH*i +: M_WIDTH];
                w_sel_we    = wes[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_pick_valid)  w_state_nxt = c_ACCESS;
            c_ACCESS: if (w_last_access) w_state_nxt = c_DONE;
            c_DONE:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_id    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            rdata     <= '0;
            r_lat_cnt <= '0;
            r_is_wr   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (w_grant) begin
                gnt_id    <= w_pick_gnt;
                mem_addr  <= w_sel_addr;
                mem_wdata <= w_sel_wdata;
                mem_we    <= w_sel_we;
                r_is_wr   <= w_sel_we;
                r_lat_cnt <= c_LAT_LOAD;
            end else if ((r_state == c_ACCESS) && !r_is_wr) begin
                if (r_lat_cnt == '0) begin
                    rdata <= mem_rdata;
                end else begin
                    r_lat_cnt <= r_lat_cnt - CNT_WIDTH'(1);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CLIENT_CNT; gi++) begin : g_ready
            assign readies[gi] = (r_state == c_DONE) && (gnt_id == GNT_WIDTH'(gi));
        end
    endgenerate

endmodule
`default_nettype wire
